// File: rtl/spi_slave_pkg.sv
// Shared constants and state encoding for the 8-lane SPI slave block receiver.
package spi_slave_pkg;

   localparam int BYTES_PER_BLOCK = 16;
   localparam int BLOCK_W         = 128;
   localparam int LANES           = 8;
   localparam int SYNC_STAGES     = 3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RECEIVE = 2'd1,
      ST_DONE    = 2'd2
   } state_e;

endpackage

// File: rtl/spi_slave_sync.sv
// Parameterized multi-stage synchronizer into the clk domain; exposes the last
// two stages so callers can build edge detectors with matched data latency.
module spi_slave_sync #(
   parameter int               WIDTH     = 1,
   parameter int               STAGES    = 3,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q_prev,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_q [0:STAGES-1];
   logic [WIDTH-1:0] stage_d [0:STAGES-1];

   always_comb begin
      stage_d[0] = d;
      for (int i = 1; i < STAGES; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= RESET_VAL;
         end
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign q_prev = stage_q[STAGES-2];
   assign q      = stage_q[STAGES-1];

endmodule

// File: rtl/spi_slave_8lane.sv
// 8-lane SPI slave: assembles 16 bytes per CS frame into a 128-bit block.
// Define SPI_SLAVE_IRQ_EN to build the irq_rx level interrupt; otherwise it is tied low.
module spi_slave_8lane
   import spi_slave_pkg::*;
(
   input  logic               clk,
   input  logic               resetn,
   input  logic               spi_clk_in,
   input  logic               spi_cs_n_in,
   input  logic [LANES-1:0]   spi_data_in,
   output logic [BLOCK_W-1:0] rx_data,
   output logic               rx_valid,
   output logic               rx_busy,
   output logic               irq_rx
);

   logic [1:0]       ctl_s2;
   logic [1:0]       ctl_s3;
   logic [LANES-1:0] data_s2;
   logic [LANES-1:0] data_s3;
   logic             unused_sync;

   // Bit 1 carries CS (idles high), bit 0 the SPI clock (idles low).
   spi_slave_sync #(
      .WIDTH     (2),
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (2'b10)
   ) u_sync_ctl (
      .clk    (clk),
      .resetn (resetn),
      .d      ({spi_cs_n_in, spi_clk_in}),
      .q_prev (ctl_s2),
      .q      (ctl_s3)
   );

   spi_slave_sync #(
      .WIDTH     (LANES),
      .STAGES    (SYNC_STAGES),
      .RESET_VAL ('0)
   ) u_sync_data (
      .clk    (clk),
      .resetn (resetn),
      .d      (spi_data_in),
      .q_prev (data_s2),
      .q      (data_s3)
   );

   assign unused_sync = ^{ctl_s2[1], data_s3};

   logic spi_clk_rising_edge;
   logic cs_n_sync;

   // Data is taken from stage 2, the same stage that flags the clock edge.
   assign spi_clk_rising_edge = ctl_s2[0] & ~ctl_s3[0];
   assign cs_n_sync           = ctl_s3[1];

   state_e             state_q,      state_d;
   logic [3:0]         byte_count_q, byte_count_d;
   logic [BLOCK_W-1:0] buffer_q,     buffer_d;
   logic               load_q,       load_d;
   logic [BLOCK_W-1:0] rx_data_q,    rx_data_d;
   logic               rx_valid_q,   rx_valid_d;

   always_comb begin
      state_d      = state_q;
      byte_count_d = byte_count_q;
      buffer_d     = buffer_q;
      load_d       = 1'b0;
      rx_data_d    = rx_data_q;
      rx_valid_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!cs_n_sync) begin
               state_d      = ST_RECEIVE;
               byte_count_d = 4'd0;
               buffer_d     = '0;
            end
         end
         ST_RECEIVE: begin
            // A byte edge wins over CS release so a last byte racing CS still completes.
            if (spi_clk_rising_edge) begin
               buffer_d[{byte_count_q, 3'b000} +: LANES] = data_s2;
               byte_count_d = byte_count_q + 4'd1;
               if (byte_count_q == 4'(BYTES_PER_BLOCK - 1)) begin
                  state_d = ST_DONE;
                  load_d  = 1'b1;
               end
            end else if (cs_n_sync) begin
               state_d      = ST_IDLE;
               byte_count_d = 4'd0;
               buffer_d     = '0;
            end
         end
         ST_DONE: begin
            if (cs_n_sync) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (load_q) begin
         rx_data_d  = buffer_q;
         rx_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         byte_count_q <= 4'd0;
         buffer_q     <= '0;
         load_q       <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_count_q <= byte_count_d;
         buffer_q     <= buffer_d;
         load_q       <= load_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
      end
   end

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign rx_busy  = (state_q == ST_RECEIVE);

`ifdef SPI_SLAVE_IRQ_EN
   logic irq_q, irq_d;

   always_comb begin
      irq_d = irq_q;
      if (state_q == ST_IDLE && !cs_n_sync) begin
         irq_d = 1'b0;
      end
      if (load_q) begin
         irq_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign irq_rx = irq_q;
`else
   assign irq_rx = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_8lane.sv
// Directed bench for spi_slave_8lane: full, partial, over-long and reset-interrupted frames.
`timescale 1ns/1ps
module tb_spi_slave_8lane;

   logic         clk = 1'b0;
   logic         resetn;
   logic         spi_clk_in;
   logic         spi_cs_n_in;
   logic [7:0]   spi_data_in;
   logic [127:0] rx_data;
   logic         rx_valid;
   logic         rx_busy;
   logic         irq_rx;

   int n_cmp = 0;
   int n_bad = 0;
   int valid_cnt = 0;
   int edge_cnt = 0;

`ifdef SPI_SLAVE_IRQ_EN
   localparam logic IRQ_EXP = 1'b1;
`else
   localparam logic IRQ_EXP = 1'b0;
`endif

   localparam logic [127:0] BLK1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] BLK2 = 128'h1b872378795f4ffd772855fc87ca964d;
   localparam logic [127:0] BLK4 = 128'h1f1e1d1c1b1a19181716151413121110;

   logic [7:0] fb [0:19];

   always #5 clk = ~clk;

   spi_slave_8lane dut (
      .clk         (clk),
      .resetn      (resetn),
      .spi_clk_in  (spi_clk_in),
      .spi_cs_n_in (spi_cs_n_in),
      .spi_data_in (spi_data_in),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_busy     (rx_busy),
      .irq_rx      (irq_rx)
   );

   always @(posedge clk) begin
      if (rx_valid) valid_cnt <= valid_cnt + 1;
      if (dut.spi_clk_rising_edge) edge_cnt <= edge_cnt + 1;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load_block(input logic [127:0] blk);
      for (int i = 0; i < 16; i++) fb[i] = blk[8*i +: 8];
   endtask

   task automatic send_byte(input logic [7:0] b, input int idx);
      int         e0;
      logic [3:0] exp_cnt;
      e0 = edge_cnt;
      spi_data_in = b;
      tick(5);
      spi_clk_in = 1'b1;
      tick(8);
      spi_clk_in = 1'b0;
      tick(5);
      exp_cnt = (idx < 16) ? 4'((idx + 1) % 16) : 4'd0;
      chk("byte_count", 128'(dut.byte_count_q), 128'(exp_cnt));
      chk("edge_pulses", 128'(edge_cnt - e0), 128'd1);
   endtask

   task automatic send_frame(input string name, input int n, input logic [127:0] exp_data,
                             input int exp_valid, input logic [1:0] exp_state, input logic exp_irq);
      int v0;
      v0 = valid_cnt;
      spi_cs_n_in = 1'b0;
      tick(5);
      chk("irq_at_cs", 128'(irq_rx), 128'd0);
      chk("busy_in_frame", 128'(rx_busy), 128'd1);
      for (int i = 0; i < n; i++) send_byte(fb[i], i);
      chk("state_before_cs_high", 128'(dut.state_q), 128'(exp_state));
      spi_cs_n_in = 1'b1;
      tick(8);
      chk("valid_pulses", 128'(valid_cnt - v0), 128'(exp_valid));
      chk("rx_data", rx_data, exp_data);
      chk("irq_end", 128'(irq_rx), 128'(exp_irq));
      chk("state_idle", 128'(dut.state_q), 128'd0);
      chk("busy_idle", 128'(rx_busy), 128'd0);
      $display("frame %s: %0d bytes, rx_data=%h, valid pulses=%0d", name, n, rx_data, valid_cnt - v0);
   endtask

   initial begin
      resetn      = 1'b0;
      spi_clk_in  = 1'b0;
      spi_cs_n_in = 1'b1;
      spi_data_in = 8'h00;
      tick(4);
      chk("rst_rx_data", rx_data, 128'd0);
      chk("rst_rx_valid", 128'(rx_valid), 128'd0);
      chk("rst_rx_busy", 128'(rx_busy), 128'd0);
      chk("rst_irq", 128'(irq_rx), 128'd0);
      chk("rst_state", 128'(dut.state_q), 128'd0);
      resetn = 1'b1;
      tick(4);

      load_block(BLK1);
      send_frame("full1", 16, BLK1, 1, 2'd2, IRQ_EXP);

      load_block(BLK2);
      send_frame("full2", 16, BLK2, 1, 2'd2, IRQ_EXP);

      load_block(BLK1);
      send_frame("partial8", 8, BLK2, 0, 2'd1, 1'b0);

      for (int i = 0; i < 16; i++) fb[i] = 8'(8'h10 + i);
      for (int i = 16; i < 20; i++) fb[i] = 8'(8'ha0 + i - 16);
      send_frame("long20", 20, BLK4, 1, 2'd2, IRQ_EXP);

      // Reset in the middle of a frame, then a clean frame afterwards.
      load_block(BLK1);
      spi_cs_n_in = 1'b0;
      tick(5);
      for (int i = 0; i < 5; i++) send_byte(fb[i], i);
      resetn = 1'b0;
      #1;
      chk("midrst_rx_data", rx_data, 128'd0);
      chk("midrst_rx_valid", 128'(rx_valid), 128'd0);
      chk("midrst_rx_busy", 128'(rx_busy), 128'd0);
      chk("midrst_irq", 128'(irq_rx), 128'd0);
      chk("midrst_state", 128'(dut.state_q), 128'd0);
      chk("midrst_byte_count", 128'(dut.byte_count_q), 128'd0);
      spi_cs_n_in = 1'b1;
      tick(3);
      resetn = 1'b1;
      tick(5);
      chk("post_rst_state", 128'(dut.state_q), 128'd0);
      send_frame("after_reset", 16, BLK1, 1, 2'd2, IRQ_EXP);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_slave_8lane.md
SPI_SLAVE_8LANE -- requirements
Module: spi_slave_8lane

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all logic runs in this domain.
REQ-002 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port spi_clk_in, input, 1 bit: SPI clock, asynchronous to clk; data is sampled on its rising edge.
REQ-004 SHALL have port spi_cs_n_in, input, 1 bit: active-low chip select, asynchronous to clk.
REQ-005 SHALL have port spi_data_in, input, 8 bits: eight data lanes, one byte per SPI clock.
REQ-006 SHALL have port rx_data, output, 128 bits: last complete block received.
REQ-007 SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rx_data updates.
REQ-008 SHALL have port rx_busy, output, 1 bit: high while a frame is being received.
REQ-009 SHALL have port irq_rx, output, 1 bit: level interrupt, block available.

Function
REQ-010 SHALL pass spi_clk_in, spi_cs_n_in and spi_data_in each through a 3-flop clk-domain synchronizer.
REQ-011 SHALL assert internal spi_clk_rising_edge for exactly one clk cycle when sync stage 2 = 1 and stage 3 = 0.
REQ-012 SHALL use the synchronized data stage aligned with spi_clk_rising_edge, so lanes are sampled with the same latency as the clock.
REQ-013 SHALL implement internal state: IDLE=0, RECEIVE=1, DONE=2.
REQ-014 IDLE: when synchronized CS is low -> RECEIVE, clear byte_count (4-bit internal counter) and the assembly buffer.
REQ-015 RECEIVE: on each spi_clk_rising_edge, write the byte into buffer[8*byte_count +: 8] (first byte -> bits [7:0], little-endian) and increment byte_count.
REQ-016 RECEIVE: on capture of the 16th byte, on the next clk load rx_data with the full buffer, pulse rx_valid for 1 cycle, set irq_rx, and go to DONE; byte_count wraps to 0.
REQ-017 DONE: ignore further SPI edges; when synchronized CS goes high -> IDLE.
REQ-018 RECEIVE with synchronized CS high before 16 bytes: abort to IDLE; discard the partial buffer; rx_data and rx_valid remain unchanged.
REQ-019 rx_data SHALL hold its value until the next complete block; a partial frame never modifies it.
REQ-020 rx_busy SHALL equal (state == RECEIVE).
REQ-021 irq_rx SHALL clear on the IDLE->RECEIVE transition.
REQ-022 If the rising edge of the 16th byte and a CS deassertion occur in the same cycle, the byte SHALL be captured and the block completed.
REQ-023 Minimum timing: spi_clk_in high and low at least 4 clk cycles each; data stable from 3 clk cycles before the rising edge until 3 clk cycles after it.

Reset
REQ-024 When resetn = 0, SHALL asynchronously set: state=IDLE, byte_count=0, buffer=0, rx_data=0, rx_valid=0, rx_busy=0, irq_rx=0, and all synchronizer flops to idle levels (clk=0, cs_n=1, data=0).
REQ-025 Reset asserted mid-frame SHALL discard the frame; after release, reception resumes only on the next CS assertion seen in IDLE.

Configuration
REQ-026 Macro SPI_SLAVE_IRQ_EN: when defined, irq_rx behaves per REQ-016/REQ-021; when undefined, irq_rx is constant 0 and its register is not synthesized.

Structure
REQ-027 Shared package spi_slave_pkg SHALL hold BYTES_PER_BLOCK=16, BLOCK_W=128, LANES=8, SYNC_STAGES=3 and the state encoding.
REQ-028 Sub-module spi_slave_sync, a parameterized-width multi-stage synchronizer, SHALL be instantiated for the clock/CS and data paths.

Verification
REQ-029 Send 16 bytes 5a,c5,b4,70,80,b7,cd,d8,30,04,7b,6a,d8,e0,c4,69 (5 clk setup, 8 high, 5 low) -> one rx_valid pulse; rx_data=69c4e0d86a7b0430d8cdb78070b4c55a; irq_rx=1.
REQ-030 Second frame, block 1b872378795f4ffd772855fc87ca964d sent LSB-first -> rx_data equals the block; irq_rx cleared at CS assert, set again at completion.
REQ-031 Frame with 8 bytes, then CS high -> no rx_valid; rx_data keeps its previous value; state returns to 0.
REQ-032 20 bytes in one frame -> rx_valid once, after byte 16; bytes 17-20 ignored; state=2 until CS high.
REQ-033 resetn pulsed low after byte 5 -> all outputs 0 immediately; a following full frame is received correctly.
REQ-034 After every byte, check byte_count increments by 1 and spi_clk_rising_edge pulses exactly once per SPI clock.
